// File: rtl/colors_to_bytes_pkg.sv
// Shared widths, phase encoding and a constant-width helper for the
// colors_to_bytes unpacker.
package colors_to_bytes_pkg;
  localparam int BYTE_LEN  = 8;
  localparam int COLOR_LEN = 12;

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction
endpackage

// File: rtl/colors_to_bytes_byte_fifo_dual_push.sv
// Byte FIFO with up to two writes and one read per cycle. push1 is only
// meaningful together with push0 (din1 lands in the slot after din0).
module byte_fifo_dual_push
  import colors_to_bytes_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push0,
  input  logic                push1,
  input  logic [BYTE_LEN-1:0] din0,
  input  logic [BYTE_LEN-1:0] din1,
  input  logic                pop,
  output logic [BYTE_LEN-1:0] head,
  output logic [CW-1:0]       count,
  output logic [CW-1:0]       free
);
  logic [BYTE_LEN-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       w_pushes;
  logic [AW-1:0]       w_wr_ptr1;

  assign w_pushes  = CW'(push0) + CW'(push1);
  assign w_wr_ptr1 = r_wr_ptr + AW'(1);
  assign head      = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign free      = CW'(DEPTH) - r_count;

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push0) r_mem[r_wr_ptr] <= din0;
    if (push1) r_mem[w_wr_ptr1] <= din1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_pushes);
      if (pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + w_pushes - CW'(pop);
    end
  end
endmodule

// File: rtl/colors_to_bytes.sv
// Unpacks 12-bit colors into bytes: two colors -> three bytes, with a
// zero-padded final byte when the stream ends on an odd color.
module colors_to_bytes
  import colors_to_bytes_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inclk,
  input  logic [COLOR_LEN-1:0] in,
  input  logic                 done_in,
  input  logic                 downstream_rdy,
  output logic                 in_rdy,
  output logic                 outclk,
  output logic [BYTE_LEN-1:0]  out,
  output logic                 done_out,
  output logic                 overflow,
  output phase_e               dbg_phase
);
  localparam int CW  = clog2(FIFO_DEPTH) + 1;
  localparam int NIB = COLOR_LEN - BYTE_LEN;

  // Handshakes: a color transfers on a cycle with inclk && in_rdy (inclk with
  // in_rdy low drops the color and sets overflow); a byte transfers on a cycle
  // with downstream_rdy && FIFO non-empty, appearing on out with outclk=1
  // right after that edge.
  phase_e              r_phase;
  logic [NIB-1:0]      r_nibble;
  logic                r_done;
  logic [CW-1:0]       w_count;
  logic [CW-1:0]       w_free;
  logic [BYTE_LEN-1:0] w_head;
  logic                w_accept;
  logic                w_pop;
  logic                w_pad;
  logic                w_fin;
  logic                w_push0;
  logic                w_push1;
  logic [BYTE_LEN-1:0] w_din0;
  logic [BYTE_LEN-1:0] w_din1;

  assign in_rdy    = (w_free >= CW'(2));
  assign w_accept  = inclk && in_rdy;
  assign w_pop     = downstream_rdy && (w_count != '0);
  assign w_pad     = r_done && (r_phase == PH_ODD) && !w_accept && (w_free >= CW'(1));
  assign w_fin     = r_done && (r_phase == PH_EVEN) && (w_count == '0) && !w_pop && !w_accept;
  assign dbg_phase = r_phase;

  always_comb begin
    w_push0 = 1'b0;
    w_push1 = 1'b0;
    w_din0  = '0;
    w_din1  = '0;
    if (w_accept) begin
      w_push0 = 1'b1;
      if (r_phase == PH_EVEN) begin
        w_din0 = in[COLOR_LEN-1 -: BYTE_LEN];
      end else begin
        w_push1 = 1'b1;
        w_din0  = {r_nibble, in[COLOR_LEN-1 -: NIB]};
        w_din1  = in[BYTE_LEN-1:0];
      end
    end else if (w_pad) begin
      w_push0 = 1'b1;
      w_din0  = {r_nibble, {NIB{1'b0}}};
    end
  end

  byte_fifo_dual_push #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push0 (w_push0),
    .push1 (w_push1),
    .din0  (w_din0),
    .din1  (w_din1),
    .pop   (w_pop),
    .head  (w_head),
    .count (w_count),
    .free  (w_free)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase  <= PH_EVEN;
      r_nibble <= '0;
      r_done   <= 1'b0;
      outclk   <= 1'b0;
      out      <= '0;
      done_out <= 1'b0;
      overflow <= 1'b0;
    end else begin
      outclk   <= w_pop;
      if (w_pop) out <= w_head;
      done_out <= w_fin;
      if (inclk && !in_rdy) overflow <= 1'b1;
      if (w_accept) begin
        if (r_phase == PH_EVEN) begin
          r_phase  <= PH_ODD;
          r_nibble <= in[NIB-1:0];
        end else begin
          r_phase <= PH_EVEN;
        end
      end else if (w_pad) begin
        r_phase <= PH_EVEN;
      end
      // A new done_in re-arms the latch even on the cycle a flush completes.
      if (done_in) r_done <= 1'b1;
      else if (w_fin) r_done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_colors_to_bytes.sv
// Bench for colors_to_bytes: bit-stream reference model feeding an expected
// byte queue, checked by a monitor whenever outclk pulses.
module tb_colors_to_bytes;
  import colors_to_bytes_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inclk = 1'b0;
  logic [11:0] in = '0;
  logic        done_in = 1'b0;
  logic        downstream_rdy = 1'b0;
  logic        in_rdy;
  logic        outclk;
  logic [7:0]  out;
  logic        done_out;
  logic        overflow;
  phase_e      dbg_phase;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [7:0]  exp_q[$];
  bit          bitq[$];
  int          exp_done = 0;
  bit          strict_done = 1'b0;
  logic        rdy_at_edge = 1'b0;
  logic        prev_outclk = 1'b0;
  bit          busy = 1'b0;

  always #5 clk = ~clk;

  colors_to_bytes #(.FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .inclk          (inclk),
    .in             (in),
    .done_in        (done_in),
    .downstream_rdy (downstream_rdy),
    .in_rdy         (in_rdy),
    .outclk         (outclk),
    .out            (out),
    .done_out       (done_out),
    .overflow       (overflow),
    .dbg_phase      (dbg_phase)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  // Reference: colors form a continuous MSB-first bit stream cut into bytes.
  task automatic model_emit();
    logic [7:0] b;
    while (bitq.size() >= 8) begin
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], bitq.pop_front()};
      exp_q.push_back(b);
    end
  endtask

  task automatic model_color(input logic [11:0] c);
    for (int i = 11; i >= 0; i--) bitq.push_back(c[i]);
    model_emit();
  endtask

  task automatic model_done();
    if (bitq.size() > 0) while (bitq.size() < 8) bitq.push_back(1'b0);
    model_emit();
    exp_done++;
  endtask

  always @(posedge clk) rdy_at_edge <= downstream_rdy;

  always @(negedge clk) begin
    if (outclk) begin
      chk("outclk_only_when_rdy", 32'(rdy_at_edge), 32'd1);
      if (exp_q.size() == 0) chk("byte_not_expected", 32'(exp_q.size()), 32'd1);
      else chk("byte_value", 32'(out), 32'(exp_q.pop_front()));
    end
    if (done_out) begin
      chk("done_out_expected", 32'(exp_done > 0), 32'd1);
      chk("done_out_after_all_bytes", 32'(exp_q.size()), 32'd0);
      if (strict_done) chk("done_out_one_after_last_byte", 32'(prev_outclk), 32'd1);
      if (exp_done > 0) exp_done--;
    end
    prev_outclk = outclk;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    exp_q.delete();
    bitq.delete();
    exp_done = 0;
    @(negedge clk);
    rst = 1'b0;
    chk({tag, "_outclk"}, 32'(outclk), 32'd0);
    chk({tag, "_out"}, 32'(out), 32'd0);
    chk({tag, "_in_rdy"}, 32'(in_rdy), 32'd1);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_done_out"}, 32'(done_out), 32'd0);
    chk({tag, "_phase"}, 32'(dbg_phase), 32'(PH_EVEN));
  endtask

  task automatic send_color(input logic [11:0] c, input bit with_done);
    int t;
    t = 0;
    while (!in_rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      chk("in_rdy_wait_timeout", 32'(in_rdy), 32'd1);
    end else begin
      inclk = 1'b1;
      in = c;
      done_in = with_done;
      model_color(c);
      if (with_done) model_done();
      @(negedge clk);
      inclk = 1'b0;
      done_in = 1'b0;
    end
  endtask

  task automatic send_done();
    done_in = 1'b1;
    model_done();
    @(negedge clk);
    done_in = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp_done != 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_done_left"}, 32'(exp_done), 32'd0);
    tick(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    do_reset("reset");

    // 1: basic unpack and first-byte latency
    downstream_rdy = 1'b1;
    send_color(12'hABC, 1'b0);
    chk("t1_no_byte_same_edge", 32'(outclk), 32'd0);
    tick();
    chk("t1_first_outclk", 32'(outclk), 32'd1);
    chk("t1_first_byte", 32'(out), 32'hAB);
    send_color(12'hDEF, 1'b0);
    drain("t1");
    chk("t1_overflow", 32'(overflow), 32'd0);

    // 2: backpressure, in_rdy gating and overflow drop
    downstream_rdy = 1'b0;
    send_color(12'h123, 1'b0);
    send_color(12'h456, 1'b0);
    chk("t2_in_rdy_low", 32'(in_rdy), 32'd0);
    inclk = 1'b1;
    in = 12'h789;
    @(negedge clk);
    inclk = 1'b0;
    chk("t2_overflow_set", 32'(overflow), 32'd1);
    chk("t2_in_rdy_still_low", 32'(in_rdy), 32'd0);
    downstream_rdy = 1'b1;
    drain("t2");
    chk("t2_overflow_sticky", 32'(overflow), 32'd1);
    do_reset("t2_reset");

    // 3: odd color count then done -> pad byte
    strict_done = 1'b1;
    send_color(12'h9A5, 1'b0);
    send_done();
    drain("t3");
    chk("t3_phase_even", 32'(dbg_phase), 32'(PH_EVEN));

    // 4: done coincident with the second color -> no pad
    send_color(12'hE1C, 1'b0);
    tick();
    send_color(12'h0F0, 1'b1);
    drain("t4");
    strict_done = 1'b0;

    // 5: ready toggling during a stream
    busy = 1'b1;
    fork
      begin
        send_color(12'h111, 1'b0);
        send_color(12'h222, 1'b0);
        send_color(12'h333, 1'b0);
        send_color(12'h444, 1'b0);
        tick(8);
        busy = 1'b0;
      end
      begin
        while (busy) begin
          downstream_rdy = ~downstream_rdy;
          @(negedge clk);
        end
      end
    join
    downstream_rdy = 1'b1;
    drain("t5");

    // 6: reset mid-stream discards nibble and FIFO contents
    downstream_rdy = 1'b0;
    send_color(12'h7AB, 1'b0);
    tick();
    do_reset("t6_reset");
    downstream_rdy = 1'b1;
    send_color(12'h001, 1'b0);
    send_color(12'h002, 1'b0);
    drain("t6");

    // Randomized bursts, each ending with done_in
    for (int burst = 0; burst < 12; burst++) begin
      int ncol;
      ncol = $urandom_range(1, 12);
      busy = 1'b1;
      fork
        begin
          for (int k = 0; k < ncol; k++) begin
            send_color(12'($urandom), 1'b0);
            tick($urandom_range(0, 2));
          end
          send_done();
          busy = 1'b0;
        end
        begin
          while (busy) begin
            downstream_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
          end
        end
      join
      downstream_rdy = 1'b1;
      drain("rand");
    end
    chk("rand_no_overflow", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
